mul8s_share_ctrl: RTL and testbench

//  Round-robin controller sharing one 8x8 signed (possibly approximate) multiplier among N_REQ requesters.

---
 rtl/mul8s_share_ctrl_pkg.sv | 6 +
 rtl/mul8s_share_ctrl_if.sv | 26 ++
 rtl/mul8s_share_ctrl_rr_arbiter.sv | 26 ++
 rtl/mul8s_share_ctrl.sv | 115 +++++++++++
 tb/tb_mul8s_share_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul8s_share_ctrl_pkg.sv
// Shared types and widths for the mul8s sharing controller and its arbiter.
package mul8s_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} mul8s_ctrl_state_e;
    localparam int MUL8S_OP_W  = 8;
    localparam int MUL8S_RES_W = 16;
endpackage

// File: rtl/mul8s_share_ctrl_if.sv
// Requester and response channels of the controller; master = requester side.
interface mul8s_share_ctrl_if
    import mul8s_pkg::*;
#(
    parameter int N_REQ = 4
) ();
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]                 req_valid;
    logic [N_REQ-1:0]                 req_ready;
    logic [N_REQ-1:0][MUL8S_OP_W-1:0] req_a;
    logic [N_REQ-1:0][MUL8S_OP_W-1:0] req_b;
    logic                             rsp_valid;
    logic                             rsp_ready;
    logic [ID_W-1:0]                  rsp_id;
    logic [MUL8S_RES_W-1:0]           rsp_o;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_o
    );
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_o
    );
endinterface

// File: rtl/mul8s_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first valid index after last_grant, wrapping.
module mul8s_rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  last_grant,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant
);
    int idx;

    // Scan farthest offset first so the nearest valid requester wins.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (req_valid[idx]) begin
                grant_valid = 1'b1;
                grant       = ID_W'(idx);
            end
        end
    end
endmodule

// File: rtl/mul8s_share_ctrl.sv
// Shares one 8x8 signed multiplier among N_REQ requesters, one operation in flight.
module mul8s_share_ctrl
    import mul8s_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 0,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    mul8s_share_ctrl_if.slave      bus,
    output logic [MUL8S_OP_W-1:0]  mul_a,
    output logic [MUL8S_OP_W-1:0]  mul_b,
    input  logic [MUL8S_RES_W-1:0] mul_o,
    output logic                   busy,
    output logic [CNT_W-1:0]       op_cnt
);
    localparam int ID_W = $clog2(N_REQ);
    localparam int LW   = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

    mul8s_ctrl_state_e      state_q, state_d;
    logic [LW-1:0]          cnt_q, cnt_d;
    logic [MUL8S_OP_W-1:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [ID_W-1:0]        rsp_id_q, rsp_id_d, last_grant_q, last_grant_d;
    logic [MUL8S_RES_W-1:0] rsp_o_q, rsp_o_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0]       op_cnt_q, op_cnt_d;
    logic                   grant_valid;
    logic [ID_W-1:0]        grant;
    logic [N_REQ-1:0]       req_ready;

    mul8s_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_valid  (bus.req_valid),
        .last_grant (last_grant_q),
        .grant_valid(grant_valid),
        .grant      (grant)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        rsp_o_d      = rsp_o_q;
        rsp_valid_d  = rsp_valid_q;
        op_cnt_d     = op_cnt_q;
        req_ready    = '0;
        unique case (state_q)
            IDLE: begin
                // ready is only raised toward a valid winner, so grant == handshake
                if (grant_valid) begin
                    req_ready[grant] = 1'b1;
                    mul_a_d      = bus.req_a[grant];
                    mul_b_d      = bus.req_b[grant];
                    rsp_id_d     = grant;
                    last_grant_d = grant;
                    cnt_d        = LW'(MUL_LAT);
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_o_d     = mul_o;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - LW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_cnt_d    = op_cnt_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            rsp_id_q     <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
            rsp_o_q      <= '0;
            rsp_valid_q  <= 1'b0;
            op_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
            rsp_o_q      <= rsp_o_d;
            rsp_valid_q  <= rsp_valid_d;
            op_cnt_q     <= op_cnt_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_o     = rsp_o_q;
    assign mul_a         = mul_a_q;
    assign mul_b         = mul_b_q;
    assign busy          = (state_q != IDLE);
    assign op_cnt        = op_cnt_q;
endmodule

// File: tb/tb_mul8s_share_ctrl.sv
// Directed bench: combinational-multiplier controller plus a 2-stage-multiplier one with a 2-bit op counter.
module tb_mul8s_share_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    mul8s_share_ctrl_if #(.N_REQ(4)) bus0 ();
    mul8s_share_ctrl_if #(.N_REQ(4)) bus1 ();

    logic [7:0]  mul_a0, mul_b0, mul_a1, mul_b1;
    logic [15:0] mul_o0, mul_o1, p1, p2;
    logic        busy0, busy1;
    logic [15:0] op_cnt0;
    logic [1:0]  op_cnt1;

    // exact signed product via 16-bit sign extension
    assign mul_o0 = {{8{mul_a0[7]}}, mul_a0} * {{8{mul_b0[7]}}, mul_b0};
    always @(posedge clk) begin
        p1 <= {{8{mul_a1[7]}}, mul_a1} * {{8{mul_b1[7]}}, mul_b1};
        p2 <= p1;
    end
    assign mul_o1 = p2;

    mul8s_share_ctrl #(.N_REQ(4), .MUL_LAT(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave),
        .mul_a(mul_a0), .mul_b(mul_b0), .mul_o(mul_o0),
        .busy(busy0), .op_cnt(op_cnt0)
    );
    mul8s_share_ctrl #(.N_REQ(4), .MUL_LAT(2), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave),
        .mul_a(mul_a1), .mul_b(mul_b1), .mul_o(mul_o1),
        .busy(busy1), .op_cnt(op_cnt1)
    );

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus0.req_valid = '0; bus0.req_a = '0; bus0.req_b = '0; bus0.rsp_ready = 1'b0;
        bus1.req_valid = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.rsp_ready = 1'b0;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        smp();
        tests_run++;
        if (bus0.rsp_valid !== 1'b0 || bus0.rsp_o !== 16'h0 || bus0.rsp_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_rsp: valid=%b o=%h id=%0d, want 0/0000/0", bus0.rsp_valid, bus0.rsp_o, bus0.rsp_id);
        end
        tests_run++;
        if (op_cnt0 !== 16'd0 || busy0 !== 1'b0 || mul_a0 !== 8'h0 || mul_b0 !== 8'h0 || bus0.req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_state: cnt=%0d busy=%b a=%h b=%h rdy=%b, want 0/0/00/00/0000", op_cnt0, busy0, mul_a0, mul_b0, bus0.req_ready);
        end
    endtask

    task automatic test_single;
        do_reset();
        bus0.req_valid = 4'b0001; bus0.req_a[0] = 8'd5; bus0.req_b[0] = 8'hFD; bus0.rsp_ready = 1'b1;
        smp();
        tests_run++;
        if (bus0.req_ready !== 4'b0001) begin
            tests_failed++; $display("FAIL single_ready: got %b want 0001", bus0.req_ready);
        end
        nxt();
        bus0.req_valid = '0;
        smp();
        tests_run++;
        if (bus0.rsp_valid !== 1'b0 || busy0 !== 1'b1 || mul_a0 !== 8'd5 || mul_b0 !== 8'hFD) begin
            tests_failed++;
            $display("FAIL single_wait: valid=%b busy=%b a=%h b=%h, want 0/1/05/fd", bus0.rsp_valid, busy0, mul_a0, mul_b0);
        end
        nxt();
        smp();
        tests_run++;
        if (bus0.rsp_valid !== 1'b1 || bus0.rsp_id !== 2'd0 || bus0.rsp_o !== 16'hFFF1) begin
            tests_failed++;
            $display("FAIL single_rsp: valid=%b id=%0d o=%h, want 1/0/fff1", bus0.rsp_valid, bus0.rsp_id, bus0.rsp_o);
        end
        nxt();
        smp();
        tests_run++;
        if (bus0.rsp_valid !== 1'b0 || op_cnt0 !== 16'd1 || busy0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done: valid=%b cnt=%0d busy=%b, want 0/1/0", bus0.rsp_valid, op_cnt0, busy0);
        end
    endtask

    task automatic test_round_robin;
        int gid[5];
        int gcyc[5];
        int ng;
        int exp_p;
        ng = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus0.req_a[i] = 8'(i + 1);
            bus0.req_b[i] = 8'(i + 2);
        end
        bus0.req_valid = 4'b1111;
        bus0.rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && ng < 5; cyc++) begin
            smp();
            if (bus0.rsp_valid === 1'b1 && ng > 0) begin
                exp_p = (gid[ng-1] + 1) * (gid[ng-1] + 2);
                tests_run++;
                if (bus0.rsp_o !== 16'(exp_p) || bus0.rsp_id !== 2'(gid[ng-1])) begin
                    tests_failed++;
                    $display("FAIL rr_rsp: o=%0d id=%0d, want %0d/%0d", bus0.rsp_o, bus0.rsp_id, exp_p, gid[ng-1]);
                end
            end
            if (bus0.req_ready !== 4'b0000) begin
                for (int j = 0; j < 4; j++) if (bus0.req_ready[j]) gid[ng] = j;
                gcyc[ng] = cyc;
                ng++;
            end
            nxt();
        end
        bus0.req_valid = '0;
        tests_run++;
        if (ng != 5) begin
            tests_failed++; $display("FAIL rr_timeout: saw %0d grants, want 5", ng);
        end else begin
            for (int k = 0; k < 5; k++) begin
                tests_run++;
                if (gid[k] != (k % 4)) begin
                    tests_failed++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, gid[k], k % 4);
                end
                if (k > 0) begin
                    tests_run++;
                    if (gcyc[k] - gcyc[k-1] != 3) begin
                        tests_failed++; $display("FAIL rr_spacing[%0d]: got %0d want 3", k, gcyc[k] - gcyc[k-1]);
                    end
                end
            end
        end
        nxt(); nxt(); nxt();
        smp();
        tests_run++;
        if (op_cnt0 !== 16'd5 || busy0 !== 1'b0) begin
            tests_failed++; $display("FAIL rr_count: cnt=%0d busy=%b, want 5/0", op_cnt0, busy0);
        end
    endtask

    task automatic run_extreme(input int id, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_o);
        bit seen;
        seen = 1'b0;
        bus0.req_valid = '0;
        bus0.req_valid[id] = 1'b1;
        bus0.req_a[id] = a; bus0.req_b[id] = b; bus0.rsp_ready = 1'b1;
        nxt();
        bus0.req_valid = '0;
        for (int c = 0; c < 8 && !seen; c++) begin
            smp();
            if (bus0.rsp_valid === 1'b1) begin
                seen = 1'b1;
                tests_run++;
                if (bus0.rsp_o !== exp_o || bus0.rsp_id !== 2'(id)) begin
                    tests_failed++;
                    $display("FAIL extreme_rsp: o=%h id=%0d, want %h/%0d", bus0.rsp_o, bus0.rsp_id, exp_o, id);
                end
            end
            nxt();
        end
        if (!seen) begin
            tests_run++; tests_failed++; $display("FAIL extreme_timeout: no rsp_valid for req %0d", id);
        end
    endtask

    task automatic test_extremes;
        do_reset();
        run_extreme(2, 8'h80, 8'h80, 16'h4000);
        run_extreme(1, 8'h80, 8'h7F, 16'hC080);
    endtask

    task automatic test_backpressure;
        do_reset();
        bus0.req_valid = 4'b1000; bus0.req_a[3] = 8'd7; bus0.req_b[3] = 8'd9; bus0.rsp_ready = 1'b0;
        smp();
        tests_run++;
        if (bus0.req_ready !== 4'b1000) begin
            tests_failed++; $display("FAIL bp_ready: got %b want 1000", bus0.req_ready);
        end
        nxt();
        bus0.req_valid = 4'b0001; bus0.req_a[0] = 8'd1; bus0.req_b[0] = 8'd1;
        nxt();
        for (int k = 0; k < 5; k++) begin
            smp();
            tests_run++;
            if (bus0.rsp_valid !== 1'b1 || bus0.rsp_o !== 16'd63 || bus0.rsp_id !== 2'd3 ||
                bus0.req_ready !== 4'b0000 || busy0 !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: valid=%b o=%0d id=%0d rdy=%b busy=%b, want 1/63/3/0000/1",
                         k, bus0.rsp_valid, bus0.rsp_o, bus0.rsp_id, bus0.req_ready, busy0);
            end
            nxt();
        end
        bus0.rsp_ready = 1'b1;
        nxt();
        smp();
        tests_run++;
        if (busy0 !== 1'b0 || bus0.rsp_valid !== 1'b0 || bus0.rsp_o !== 16'd63 ||
            bus0.req_ready !== 4'b0001 || op_cnt0 !== 16'd1) begin
            tests_failed++;
            $display("FAIL bp_release: busy=%b valid=%b o=%0d rdy=%b cnt=%0d, want 0/0/63/0001/1",
                     busy0, bus0.rsp_valid, bus0.rsp_o, bus0.req_ready, op_cnt0);
        end
        nxt();
        bus0.req_valid = '0;
        nxt(); nxt();
    endtask

    task automatic test_latency2;
        do_reset();
        bus1.req_valid = 4'b0010; bus1.req_a[1] = 8'hFA; bus1.req_b[1] = 8'd11; bus1.rsp_ready = 1'b1;
        smp();
        tests_run++;
        if (bus1.req_ready !== 4'b0010) begin
            tests_failed++; $display("FAIL lat2_ready: got %b want 0010", bus1.req_ready);
        end
        nxt();
        bus1.req_valid = '0;
        for (int k = 1; k <= 3; k++) begin
            smp();
            tests_run++;
            if (mul_a1 !== 8'hFA || mul_b1 !== 8'd11 || bus1.rsp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL lat2_wait[t+%0d]: a=%h b=%h valid=%b, want fa/0b/0", k, mul_a1, mul_b1, bus1.rsp_valid);
            end
            nxt();
        end
        smp();
        tests_run++;
        if (bus1.rsp_valid !== 1'b1 || bus1.rsp_o !== 16'hFFBE || bus1.rsp_id !== 2'd1) begin
            tests_failed++;
            $display("FAIL lat2_rsp: valid=%b o=%h id=%0d, want 1/ffbe/1", bus1.rsp_valid, bus1.rsp_o, bus1.rsp_id);
        end
        nxt();
        smp();
        tests_run++;
        if (op_cnt1 !== 2'd1) begin
            tests_failed++; $display("FAIL lat2_cnt: got %0d want 1", op_cnt1);
        end
    endtask

    task automatic test_cnt_wrap;
        logic [1:0] exp_cnt;
        for (int n = 0; n < 3; n++) begin
            exp_cnt = 2'(n + 2);
            nxt();
            bus1.req_valid = 4'b0001; bus1.req_a[0] = 8'd2; bus1.req_b[0] = 8'd3;
            smp();
            tests_run++;
            if (bus1.req_ready !== 4'b0001) begin
                tests_failed++; $display("FAIL wrap_ready[%0d]: got %b want 0001", n, bus1.req_ready);
            end
            nxt();
            bus1.req_valid = '0;
            nxt(); nxt(); nxt(); nxt();
            smp();
            tests_run++;
            if (op_cnt1 !== exp_cnt || busy1 !== 1'b0 || bus1.rsp_o !== 16'd6) begin
                tests_failed++;
                $display("FAIL wrap_cnt[%0d]: cnt=%0d busy=%b o=%0d, want %0d/0/6", n, op_cnt1, busy1, bus1.rsp_o, exp_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_op;
        do_reset();
        bus0.req_valid = 4'b0100; bus0.req_a[2] = 8'd3; bus0.req_b[2] = 8'd4; bus0.rsp_ready = 1'b1;
        smp();
        tests_run++;
        if (bus0.req_ready !== 4'b0100) begin
            tests_failed++; $display("FAIL rstmid_ready: got %b want 0100", bus0.req_ready);
        end
        nxt();
        bus0.req_valid = '0;
        rst = 1'b1;
        smp();
        tests_run++;
        if (busy0 !== 1'b1) begin
            tests_failed++; $display("FAIL rstmid_inflight: busy=%b want 1", busy0);
        end
        nxt();
        rst = 1'b0;
        bus0.req_valid = 4'b1111;
        smp();
        tests_run++;
        if (bus0.rsp_valid !== 1'b0 || busy0 !== 1'b0 || mul_a0 !== 8'h0 || mul_b0 !== 8'h0 ||
            bus0.rsp_o !== 16'h0 || bus0.rsp_id !== 2'd0 || op_cnt0 !== 16'd0) begin
            tests_failed++;
            $display("FAIL rstmid_state: valid=%b busy=%b a=%h b=%h o=%h id=%0d cnt=%0d, want all zero",
                     bus0.rsp_valid, busy0, mul_a0, mul_b0, bus0.rsp_o, bus0.rsp_id, op_cnt0);
        end
        tests_run++;
        if (bus0.req_ready !== 4'b0001) begin
            tests_failed++; $display("FAIL rstmid_grant: got %b want 0001", bus0.req_ready);
        end
        bus0.req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_extremes();
        test_backpressure();
        test_latency2();
        test_cnt_wrap();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
